// File: rtl/mod_n_up_down_counter.sv
// ---------------------------------------------------------------------------
// mod_n_up_down_counter
//   Modulo-N synchronous up/down counter with count enable, synchronous clear,
//   parallel load, terminal count and a carry/borrow pulse for cascading.
//   Stages chain by wiring co of one stage to en of the next.
//
// Parameters
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active-high (q=0, qb=all ones)
//   en    in   count enable
//   clr   in   synchronous clear (highest priority)
//   load  in   synchronous load of d (out-of-range d loads 0)
//   M     in   direction: 0 = up, 1 = down
//   d     in   load value
//   q     out  registered count
//   qb    out  registered complement of q
//   tc    out  terminal count for the current direction (combinational)
//   co    out  carry/borrow pulse, asserted in the cycle whose edge wraps
//
// Configuration
//   MOD_COUNTER_SAT_EN  when defined, counting saturates at the range ends
//                       instead of wrapping and co is tied low.
// ---------------------------------------------------------------------------
module mod_n_up_down_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             M,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             co
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the load check.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_up_down_counter: MODULUS %0d outside [2, 2**WIDTH]", MODULUS);
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] qb_q;
  logic             at_max, at_zero, d_ok;

  assign at_max  = (cnt_q == MAX_V);
  assign at_zero = (cnt_q == '0);
  assign d_ok    = ({1'b0, d} < MOD_X);

  // End-of-range values: wrap to the other end, or stick when saturating.
`ifdef MOD_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] UP_END = MAX_V;
  localparam logic [WIDTH-1:0] DN_END = '0;
`else
  localparam logic [WIDTH-1:0] UP_END = '0;
  localparam logic [WIDTH-1:0] DN_END = MAX_V;
`endif

  // Priority clr > load > en > hold. d only reaches cnt_d through the load
  // branch, so an undriven d cannot pollute the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = d_ok ? d : '0;
    end else if (en) begin
      if (!M) cnt_d = at_max  ? UP_END : cnt_q + WIDTH'(1);
      else    cnt_d = at_zero ? DN_END : cnt_q - WIDTH'(1);
    end
  end

  // qb is registered from ~cnt_d so it changes on exactly the same edge as q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      qb_q  <= '1;
    end else begin
      cnt_q <= cnt_d;
      qb_q  <= ~cnt_d;
    end
  end

  assign q  = cnt_q;
  assign qb = qb_q;
  assign tc = (~M & at_max) | (M & at_zero);

`ifdef MOD_COUNTER_SAT_EN
  assign co = 1'b0;
`else
  assign co = tc & en & ~clr & ~load;
`endif

endmodule

// File: tb/tb_mod_n_up_down_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_n_up_down_counter
//   Self-checking bench for mod_n_up_down_counter (WIDTH=4, MODULUS=12):
//   directed scenarios, a two-stage cascade and randomized control traffic,
//   all compared against an integer reference model.
// ---------------------------------------------------------------------------
module tb_mod_n_up_down_counter;

  localparam int W   = 4;
  localparam int MOD = 12;
`ifdef MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, clr, load, M;
  logic [W-1:0] d, q, qb;
  logic         tc, co;

  // cascade pair
  logic         c_rst;
  logic [W-1:0] qa, qba, qbb, qbq;
  logic         tca, coa, tcb, cob;

  int n_chk = 0;
  int n_err = 0;
  int mq;

  always #5 clk = ~clk;

  mod_n_up_down_counter #(.WIDTH(W), .MODULUS(MOD)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .M(M),
    .d(d), .q(q), .qb(qb), .tc(tc), .co(co)
  );

  mod_n_up_down_counter #(.WIDTH(W), .MODULUS(MOD)) u_cas_a (
    .clk(clk), .rst(c_rst), .en(1'b1), .clr(1'b0), .load(1'b0), .M(1'b0),
    .d(4'd0), .q(qa), .qb(qba), .tc(tca), .co(coa)
  );

  mod_n_up_down_counter #(.WIDTH(W), .MODULUS(MOD)) u_cas_b (
    .clk(clk), .rst(c_rst), .en(coa), .clr(1'b0), .load(1'b0), .M(1'b0),
    .d(4'd0), .q(qbq), .qb(qbb), .tc(tcb), .co(cob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: counting as modular arithmetic on plain integers.
  function automatic int f_next(input int cur, input bit e, input bit c,
                                input bit l, input bit m, input int dv);
    if (c) return 0;
    if (l) return (dv < MOD) ? dv : 0;
    if (!e) return cur;
    if (!m) begin
      if (SAT && cur == MOD - 1) return cur;
      return (cur + 1) % MOD;
    end
    if (SAT && cur == 0) return 0;
    return (cur - 1 + MOD) % MOD;
  endfunction

  function automatic bit f_tc(input int cur, input bit m);
    return m ? (cur == 0) : (cur == MOD - 1);
  endfunction

  function automatic bit f_co(input int cur, input bit e, input bit c,
                              input bit l, input bit m);
    if (SAT) return 1'b0;
    return f_tc(cur, m) && e && !c && !l;
  endfunction

  // Called at a falling edge: drive, check combinational outputs, clock,
  // then check the registered outputs at the next falling edge.
  task automatic cyc(input bit e, input bit c, input bit l, input bit m,
                     input int dv, input string tag);
    en = e; clr = c; load = l; M = m; d = 4'(dv);
    #1;
    chk({tag, ".tc"}, 32'(tc), 32'(f_tc(mq, m)));
    chk({tag, ".co"}, 32'(co), 32'(f_co(mq, e, c, l, m)));
    @(posedge clk);
    mq = f_next(mq, e, c, l, m, dv);
    @(negedge clk);
    chk({tag, ".q"},  32'(q),  32'(mq));
    chk({tag, ".qb"}, 32'(qb), 32'((~mq) & 15));
  endtask

  initial begin
    int a, b;
    bit bco;
    rst = 1'b1; c_rst = 1'b1;
    en = 1'b0; clr = 1'b0; load = 1'b0; M = 1'b0; d = '0;
    #3;
    chk("reset.q",  32'(q),  32'd0);
    chk("reset.qb", 32'(qb), 32'd15);
    @(negedge clk);
    rst = 1'b0;
    mq  = 0;

    // 1: count up through a full wrap
    for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, 0, "up");
    // 2: from 0, count down
    cyc(1, 1, 0, 0, 0, "clr0");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, "down");
    // 3: load, direction toggling, out-of-range load, clr vs load
    cyc(0, 0, 1, 0, 5, "ld5");
    cyc(1, 0, 0, 0, 0, "tog0");
    cyc(1, 0, 0, 1, 0, "tog1");
    cyc(1, 0, 0, 1, 0, "tog2");
    cyc(0, 0, 1, 0, 13, "ld13");
    cyc(0, 0, 1, 0, 11, "ld11");
    cyc(1, 1, 1, 0, 7, "clrld");
    // 4: asynchronous reset mid-cycle
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, "to7");
    chk("pre_rst.q", 32'(q), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("arst.q",  32'(q),  32'd0);
    chk("arst.qb", 32'(qb), 32'd15);
    mq = 0;
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0, "hold0");
    cyc(0, 0, 0, 1, 9, "hold0b");
    // 6: range ends (saturate or wrap depending on build)
    cyc(0, 0, 1, 0, 10, "ld10");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, "top");
    cyc(1, 1, 0, 1, 0, "clr1");
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 1, 0, "bot");

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
          $urandom_range(7, 0) == 0, 1'($urandom), int'($urandom_range(15, 0)),
          "rnd");
    end

    // 5: two cascaded stages
    c_rst = 1'b0;
    a = 0; b = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      bco = f_co(a, 1, 0, 0, 0);
      b = f_next(b, bco, 0, 0, 0, 0);
      a = f_next(a, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("cas.a", 32'(qa), 32'(a));
      chk("cas.b", 32'(qbq), 32'(b));
    end
    if (SAT) begin
      chk("cas.end_a", 32'(qa),  32'd11);
      chk("cas.end_b", 32'(qbq), 32'd0);
    end else begin
      chk("cas.end_a", 32'(qa),  32'd6);
      chk("cas.end_b", 32'(qbq), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
